// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions used by the transmitter and its parity helper.
//   - parity mode encoding (matches the receiver's encoding)
//   - offset between the dataBits field and the real data bit count
//   - transmitter state encoding
//   - break length in bit periods
package uart_transmitter_pkg;

  localparam logic [1:0] PARITY_SPACE = 2'b00;
  localparam logic [1:0] PARITY_ODD   = 2'b01;
  localparam logic [1:0] PARITY_EVEN  = 2'b10;
  localparam logic [1:0] PARITY_MARK  = 2'b11;

  // Number of data bits on the line = dataBits + DATA_BITS_OFFSET.
  localparam int DATA_BITS_OFFSET = 5;

  localparam logic [2:0] STATE_IDLE   = 3'd0;
  localparam logic [2:0] STATE_START  = 3'd1;
  localparam logic [2:0] STATE_DATA   = 3'd2;
  localparam logic [2:0] STATE_PARITY = 3'd3;
  localparam logic [2:0] STATE_STOP   = 3'd4;
  localparam logic [2:0] STATE_BREAK  = 3'd5;

  // Break holds the line low for this many bit periods before the
  // one-period mark-after-break.
  localparam int BREAK_PERIODS = 24;

endpackage

// File: rtl/uart_parity_generator.sv
// Combinational UART parity bit generator.
// Only the active data bits (dataBits + 5 of them) contribute to the parity.
// Ports:
//   data       [7:0] character, bits above the active count are ignored
//   dataBits   [1:0] data bit count minus 5
//   parityMode [1:0] 00 space, 11 mark, 10 even, 01 odd
//   parity           parity bit to put on the line
module uart_parity_generator
  import uart_transmitter_pkg::*;
(
  input  logic [7:0] data,
  input  logic [1:0] dataBits,
  input  logic [1:0] parityMode,
  output logic       parity
);

  logic [7:0] activeMask;
  logic       dataXor;

  always_comb begin
    // dataBits=3 keeps all 8 bits, dataBits=0 keeps the low 5.
    activeMask = 8'hFF >> (2'd3 - dataBits);
    dataXor    = ^(data & activeMask);
    parity     = 1'b0;
    case (parityMode)
      PARITY_SPACE: parity = 1'b0;
      PARITY_MARK:  parity = 1'b1;
      PARITY_EVEN:  parity = dataXor;
      PARITY_ODD:   parity = ~dataXor;
      default:      parity = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter with a one-entry holding register.
// Frame: start bit, 5..8 data bits LSB first, optional parity, 1 or 2 stops.
// Bit period is 2*clockDivisor+1 clk cycles. A break drives the line low for
// 24 bit periods followed by one mark period.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   dataBits      data bit count minus 5
//   hasParity     append a parity bit
//   parityMode    00 space, 11 mark, 10 even, 01 odd
//   extraStopBit  two stop bits when set
//   clockDivisor  bit period = 2*clockDivisor+1 clocks
//   dataIn        character to send, captured on sendReq when ready
//   sendReq       one-cycle write strobe
//   sendBreak     one-cycle break request, honoured only when fully idle
//   ready         holding register empty
//   busy          frame or break in progress (or character waiting)
//   tx            registered serial output, idle high
//
// state  | meaning
// IDLE   | line high, waiting for a held character or a break request
// START  | start bit (low) for one period
// DATA   | data bits, LSB first, one period each
// PARITY | parity bit for one period
// STOP   | stop bit(s), high, one or two periods
// BREAK  | 24 low periods then one high period
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int CLOCK_DIVISOR_WIDTH = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     dataBits,
  input  logic                           hasParity,
  input  logic [1:0]                     parityMode,
  input  logic                           extraStopBit,
  input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
  input  logic [7:0]                     dataIn,
  input  logic                           sendReq,
  input  logic                           sendBreak,
  output logic                           ready,
  output logic                           busy,
  output logic                           tx
);

  logic [2:0]                     state;
  logic                           holdValid;
  logic [7:0]                     holdData;

  // Frame settings latched at load time so mid-frame config changes are inert.
  logic [7:0]                     frameData;
  logic [7:0]                     shiftData;
  logic [1:0]                     frameBits;
  logic                           frameHasParity;
  logic [1:0]                     frameParityMode;
  logic                           frameExtraStop;
  logic [CLOCK_DIVISOR_WIDTH-1:0] frameDivisor;

  // One bit wider than the divisor so 2*divisor never overflows.
  logic [CLOCK_DIVISOR_WIDTH:0]   periodCnt;
  logic [4:0]                     bitIdx;
  logic                           txReg;
  logic                           parityBit;

  logic                           periodDone;
  logic [4:0]                     lastDataIdx;
  logic                           lastStop;
  logic                           breakDone;
  logic                           frameEnd;
  logic                           loadNow;
  logic                           acceptReq;
  logic                           startBreak;

  uart_parity_generator parityGen (
    .data       (frameData),
    .dataBits   (frameBits),
    .parityMode (frameParityMode),
    .parity     (parityBit)
  );

  always_comb begin
    periodDone  = (periodCnt == '0);
    lastDataIdx = 5'(frameBits) + 5'(DATA_BITS_OFFSET - 1);
    lastStop    = !frameExtraStop || bitIdx[0];
    breakDone   = (bitIdx == 5'(BREAK_PERIODS));
    // Last period of a stop sequence or of mark-after-break: a waiting
    // character can start right here without passing through IDLE.
    frameEnd    = periodDone &&
                  (((state == STATE_STOP) && lastStop) ||
                   ((state == STATE_BREAK) && breakDone));
    loadNow     = holdValid && ((state == STATE_IDLE) || frameEnd);
    acceptReq   = sendReq && !holdValid;
    // A simultaneous sendReq wins over sendBreak.
    startBreak  = (state == STATE_IDLE) && !holdValid && sendBreak && !sendReq;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= STATE_IDLE;
      holdValid       <= 1'b0;
      holdData        <= '0;
      frameData       <= '0;
      shiftData       <= '0;
      frameBits       <= '0;
      frameHasParity  <= 1'b0;
      frameParityMode <= '0;
      frameExtraStop  <= 1'b0;
      frameDivisor    <= '0;
      periodCnt       <= '0;
      bitIdx          <= '0;
      txReg           <= 1'b1;
    end else begin
      // A load only happens with holdValid set, so it never collides with
      // an accept in the same cycle.
      if (loadNow) begin
        holdValid <= 1'b0;
      end else if (acceptReq) begin
        holdValid <= 1'b1;
        holdData  <= dataIn;
      end

      if (loadNow) begin
        state           <= STATE_START;
        txReg           <= 1'b0;
        frameData       <= holdData;
        shiftData       <= holdData;
        frameBits       <= dataBits;
        frameHasParity  <= hasParity;
        frameParityMode <= parityMode;
        frameExtraStop  <= extraStopBit;
        frameDivisor    <= clockDivisor;
        periodCnt       <= {clockDivisor, 1'b0};
        bitIdx          <= '0;
      end else if (startBreak) begin
        state        <= STATE_BREAK;
        txReg        <= 1'b0;
        frameDivisor <= clockDivisor;
        periodCnt    <= {clockDivisor, 1'b0};
        bitIdx       <= '0;
      end else if (state != STATE_IDLE) begin
        if (!periodDone) begin
          periodCnt <= periodCnt - 1'b1;
        end else begin
          periodCnt <= {frameDivisor, 1'b0};
          case (state)
            STATE_START: begin
              state  <= STATE_DATA;
              txReg  <= shiftData[0];
              bitIdx <= '0;
            end
            STATE_DATA: begin
              if (bitIdx == lastDataIdx) begin
                bitIdx <= '0;
                if (frameHasParity) begin
                  state <= STATE_PARITY;
                  txReg <= parityBit;
                end else begin
                  state <= STATE_STOP;
                  txReg <= 1'b1;
                end
              end else begin
                shiftData <= shiftData >> 1;
                txReg     <= shiftData[1];
                bitIdx    <= bitIdx + 1'b1;
              end
            end
            STATE_PARITY: begin
              state  <= STATE_STOP;
              txReg  <= 1'b1;
              bitIdx <= '0;
            end
            STATE_STOP: begin
              if (!lastStop) begin
                bitIdx <= bitIdx + 1'b1;
              end else begin
                state <= STATE_IDLE;
                txReg <= 1'b1;
              end
            end
            STATE_BREAK: begin
              if (breakDone) begin
                state <= STATE_IDLE;
                txReg <= 1'b1;
              end else begin
                bitIdx <= bitIdx + 1'b1;
                // The final period of the break is the mark-after-break.
                txReg  <= (bitIdx == 5'(BREAK_PERIODS - 1));
              end
            end
            default: begin
              state <= STATE_IDLE;
              txReg <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign ready = !holdValid;
  assign busy  = !((state == STATE_IDLE) && !holdValid);
  assign tx    = txReg;

endmodule
